serdes_tx: RTL and testbench

- 8b/10b transmitter for the SERDES link. It is the send end that feeds the RX block's serial input.
- It accepts bytes over a valid/ready handshake and encodes each byte to a 10-bit codeword while tracking running disparity.
- It serializes each codeword MSB-first, one bit per clkTX cycle.
- After enable it sends a K28.5 comma burst for receiver alignment, then data, and inserts K28.5 idle fill whenever no byte is pending.

---
 rtl/serdes_pkg.sv | 46 ++++
 rtl/serdes_tx_if.sv | 9 +
 rtl/encoder_8b10b.sv | 54 +++++
 rtl/serdes_tx.sv | 108 ++++++++++
 tb/tb_serdes_tx.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serdes_pkg.sv
// Shared 8b/10b definitions for the SERDES link: comma codewords, FSM states
// and the RD- column lookup tables for the 5b/6b and 3b/4b sub-blocks.
package serdes_pkg;

    // K28.5 comma in both running-disparity columns (abcdei_fghj order)
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } tx_state_t;

    // 5b/6b codes (abcdei) for D.0 .. D.31, RD- column.
    // The RD+ column is the complement for unbalanced codes and for D.7.
    localparam logic [0:31][5:0] ENC6_RDN = {
        6'b100111, 6'b011101, 6'b101101, 6'b110001,
        6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110,
        6'b001110, 6'b101110, 6'b011110, 6'b101011
    };

    // 3b/4b codes (fghj) for D.x.0 .. D.x.P7, RD- column.
    // The RD+ column is the complement for unbalanced codes and for D.x.3.
    localparam logic [0:7][3:0] ENC4_RDN = {
        4'b1011, 4'b1001, 4'b0101, 4'b1100,
        4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    // Alternate D.x.A7 encoding, RD- column; avoids a run of five
    localparam logic [3:0] ENC4_A7_RDN = 4'b0111;

    function automatic logic is_bal6(input logic [5:0] v);
        return ($countones(v) == 3);
    endfunction

    function automatic logic is_bal4(input logic [3:0] v);
        return ($countones(v) == 2);
    endfunction

endpackage

// File: rtl/serdes_tx_if.sv
// Byte handshake between the upstream source and the 8b/10b transmitter.
interface serdes_tx_if;
    logic [7:0] dataIn;
    logic       dataValid;
    logic       dataReady;

    modport master (output dataIn, output dataValid, input dataReady);
    modport slave  (input dataIn, input dataValid, output dataReady);
endinterface

// File: rtl/encoder_8b10b.sv
// Combinational 8b/10b encoder: D.x.y with alternate A7 handling, plus K28.5.
// rdIn = 0 means running disparity is positive (RD+ column is used).
module encoder_8b10b
    import serdes_pkg::*;
(
    input  logic [7:0] data,
    input  logic       k,
    input  logic       rdIn,
    output logic [9:0] code,
    output logic       rdOut
);

    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_rdPos;
    logic [5:0] w_6b;
    logic [3:0] w_4b;
    logic       w_bal6;
    logic       w_bal4;
    logic       w_midPos;
    logic       w_useA7;

    assign w_x     = data[4:0];
    assign w_y     = data[7:5];
    assign w_rdPos = ~rdIn;

    // Encode 5b/6b, then choose the 3b/4b column from the disparity after it
    always_comb begin
        w_6b   = ENC6_RDN[w_x];
        w_bal6 = is_bal6(w_6b);
        if (w_rdPos && (!w_bal6 || (w_6b == 6'b111000))) begin
            w_6b = ~w_6b;
        end
        w_midPos = w_bal6 ? w_rdPos : ~w_rdPos;

        w_useA7 = (w_y == 3'd7) &&
                  ((!w_midPos && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
                   ( w_midPos && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))));
        w_4b   = w_useA7 ? ENC4_A7_RDN : ENC4_RDN[w_y];
        w_bal4 = is_bal4(w_4b);
        if (w_midPos && (!w_bal4 || (w_4b == 4'b1100))) begin
            w_4b = ~w_4b;
        end

        if (k) begin
            code  = rdIn ? K28_5_RDN : K28_5_RDP;
            rdOut = ~rdIn;
        end else begin
            code  = {w_6b, w_4b};
            rdOut = rdIn ^ ~w_bal6 ^ ~w_bal4;
        end
    end

endmodule

// File: rtl/serdes_tx.sv
// 8b/10b serial transmitter: comma alignment burst after enable, then data
// words with K28.5 idle fill, serialized MSB-first one bit per clkTX.
module serdes_tx #(
    parameter int NUM_SYNC = 4
) (
    input  logic        clkTX,
    input  logic        resetN,
    input  logic        enable,
    serdes_tx_if.slave  up,
    output logic        SerialOut,
    output logic        tick10,
    output logic        syncDone,
    output logic        rdState
);
    import serdes_pkg::*;

    localparam logic [3:0] SYNC_LAST = 4'(NUM_SYNC);

    tx_state_t  r_state;
    logic [9:0] r_shreg;
    logic [3:0] r_bitCnt;
    logic       r_rd;
    logic [3:0] r_syncCnt;

    logic       w_boundary;
    logic       w_lastSync;
    logic       w_runLoad;
    logic       w_encK;
    logic [9:0] w_code;
    logic       w_rdOut;

    // Last bit of a word while the link is active
    assign w_boundary = (r_state != ST_IDLE) && (r_bitCnt == 4'd9);
    assign w_lastSync = (r_state == ST_SYNC) && (r_syncCnt >= SYNC_LAST);
    // Boundary where the next word follows RUN rules (data or idle fill)
    assign w_runLoad  = w_boundary && enable && ((r_state == ST_RUN) || w_lastSync);
    assign w_encK     = !(w_runLoad && up.dataValid);

    encoder_8b10b u_enc (
        .data  (up.dataIn),
        .k     (w_encK),
        .rdIn  (r_rd),
        .code  (w_code),
        .rdOut (w_rdOut)
    );

    assign up.dataReady = w_runLoad;
    assign SerialOut    = r_shreg[9];
    assign tick10       = w_boundary;
    assign syncDone     = (r_state == ST_RUN);
    assign rdState      = r_rd;

    // Link FSM: word loads at bit 9, shifting in between, disable at word end
    always_ff @(posedge clkTX or negedge resetN) begin
        if (!resetN) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bitCnt  <= '0;
            r_rd      <= 1'b0;
            r_syncCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_shreg   <= '0;
                    r_bitCnt  <= '0;
                    r_rd      <= 1'b0;
                    r_syncCnt <= '0;
                    if (enable) begin
                        r_shreg   <= K28_5_RDP;
                        r_rd      <= 1'b1;
                        r_syncCnt <= 4'd1;
                        r_state   <= ST_SYNC;
                    end
                end
                ST_SYNC, ST_RUN: begin
                    if (!w_boundary) begin
                        r_shreg  <= {r_shreg[8:0], 1'b0};
                        r_bitCnt <= r_bitCnt + 4'd1;
                    end else if (!enable) begin
                        r_state   <= ST_IDLE;
                        r_shreg   <= '0;
                        r_bitCnt  <= '0;
                        r_rd      <= 1'b0;
                        r_syncCnt <= '0;
                    end else begin
                        r_shreg  <= w_code;
                        r_rd     <= w_rdOut;
                        r_bitCnt <= '0;
                        if (r_state == ST_SYNC) begin
                            if (w_lastSync) begin
                                r_state <= ST_RUN;
                            end else begin
                                r_syncCnt <= r_syncCnt + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_shreg  <= '0;
                    r_bitCnt <= '0;
                    r_rd     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_tx.sv
// Self-checking bench for serdes_tx: word-level reference model built from
// explicit two-column 8b/10b tables and a slot-based link schedule.
module tb_serdes_tx;

    localparam int NUM_SYNC = 4;
    localparam logic [9:0] COMMA_P = 10'b1100000101;
    localparam logic [9:0] COMMA_N = 10'b0011111010;

    localparam logic [5:0] T6N [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};

    logic clkTX = 1'b0;
    logic resetN;
    logic enable;
    logic SerialOut, tick10, syncDone, rdState;

    serdes_tx_if u_if ();

    serdes_tx #(.NUM_SYNC(NUM_SYNC)) dut (
        .clkTX     (clkTX),
        .resetN    (resetN),
        .enable    (enable),
        .up        (u_if),
        .SerialOut (SerialOut),
        .tick10    (tick10),
        .syncDone  (syncDone),
        .rdState   (rdState)
    );

    always #5 clkTX = ~clkTX;

    int vectors = 0;
    int miscompares = 0;
    int m_word;
    bit m_rd;

    // Reference 8b/10b: returns {next rdState, codeword}; rd=0 means RD+ column
    function automatic logic [10:0] ref_enc(input logic [7:0] b, input bit k, input bit rd);
        logic [5:0] s6;
        logic [3:0] s4;
        logic [9:0] cw;
        bit pos;
        int x, y;
        pos = (rd == 1'b0);
        if (k) begin
            cw = pos ? COMMA_P : COMMA_N;
        end else begin
            x = int'(b[4:0]);
            y = int'(b[7:5]);
            s6 = pos ? T6P[x] : T6N[x];
            if ($countones(s6) != 3) pos = !pos;
            if (y == 7 && ((!pos && (x == 17 || x == 18 || x == 20)) ||
                           ( pos && (x == 11 || x == 13 || x == 14))))
                s4 = pos ? 4'b1000 : 4'b0111;
            else
                s4 = pos ? T4P[y] : T4N[y];
            cw = {s6, s4};
        end
        return {(($countones(cw) != 5) ? !rd : rd), cw};
    endfunction

    // Word slot schedule: burst commas first, then data if offered else comma
    task automatic model_next(input bit v, input logic [7:0] b,
                              output logic [9:0] ec, output logic [9:0] erm, output logic [9:0] esm);
        logic [10:0] e;
        e    = ref_enc(b, (m_word < NUM_SYNC) || !v, m_rd);
        m_rd = e[10];
        ec   = e[9:0];
        erm  = (m_word + 1 >= NUM_SYNC) ? 10'b0000000001 : 10'b0;
        esm  = (m_word >= NUM_SYNC) ? 10'h3FF : 10'h000;
        m_word++;
    endtask

    // Offer (v,b) for the next boundary, then record the following word
    task automatic slot(input bit v, input logic [7:0] b,
                        output logic [9:0] got, output logic [9:0] tm,
                        output logic [9:0] rm, output logic [9:0] sm, output logic rdo);
        u_if.dataValid = v;
        u_if.dataIn    = b;
        got = '0; tm = '0; rm = '0; sm = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clkTX); #1;
            got = {got[8:0], SerialOut};
            tm  = {tm[8:0], tick10};
            rm  = {rm[8:0], u_if.dataReady};
            sm  = {sm[8:0], syncDone};
        end
        rdo = rdState;
    endtask

    task automatic test_reset;
        resetN = 1'b1; enable = 1'b0; u_if.dataValid = 1'b0; u_if.dataIn = 8'h00;
        #3 resetN = 1'b0;
        repeat (2) @(posedge clkTX);
        #1;
        vectors++;
        if ({SerialOut, u_if.dataReady, tick10, syncDone, rdState} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outs: got %b want 00000",
                     {SerialOut, u_if.dataReady, tick10, syncDone, rdState});
        end
        resetN = 1'b1;
        @(posedge clkTX); #1;
        vectors++;
        if ({SerialOut, tick10, syncDone} !== 3'b0) begin
            miscompares++;
            $display("FAIL idle_outs: got %b want 000", {SerialOut, tick10, syncDone});
        end
        m_word = 0; m_rd = 1'b0;
    endtask

    task automatic test_sync_burst;
        logic [9:0] got, tm, rm, sm, ec, erm, esm, want;
        logic rdo;
        enable = 1'b1;
        for (int w = 0; w < NUM_SYNC; w++) begin
            slot(1'b0, 8'h00, got, tm, rm, sm, rdo);
            model_next(1'b0, 8'h00, ec, erm, esm);
            want = (w % 2 == 1) ? COMMA_N : COMMA_P;
            vectors++;
            if (got !== want) begin miscompares++; $display("FAIL burst_word%0d: got %b want %b", w, got, want); end
            vectors++;
            if (tm !== 10'b0000000001) begin miscompares++; $display("FAIL burst_tick%0d: got %b want 0000000001", w, tm); end
            vectors++;
            if (rm !== erm) begin miscompares++; $display("FAIL burst_ready%0d: got %b want %b", w, rm, erm); end
            vectors++;
            if (sm !== 10'h000) begin miscompares++; $display("FAIL burst_syncdone%0d: got %b want 0000000000", w, sm); end
            vectors++;
            if (rdo !== m_rd) begin miscompares++; $display("FAIL burst_rd%0d: got %b want %b", w, rdo, m_rd); end
        end
        vectors++;
        if (rdState !== 1'b0) begin miscompares++; $display("FAIL burst_final_rd: got %b want 0", rdState); end
    endtask

    task automatic test_first_data;
        logic [9:0] got, tm, rm, sm, ec, erm, esm;
        logic rdo;
        slot(1'b1, 8'h00, got, tm, rm, sm, rdo);
        model_next(1'b1, 8'h00, ec, erm, esm);
        vectors++;
        if (got !== 10'b0110001011) begin miscompares++; $display("FAIL d00_word: got %b want 0110001011", got); end
        vectors++;
        if (sm !== 10'h3FF) begin miscompares++; $display("FAIL d00_syncdone: got %b want 1111111111", sm); end
        vectors++;
        if (rdo !== 1'b0) begin miscompares++; $display("FAIL d00_rd: got %b want 0", rdo); end
        vectors++;
        if (rm !== 10'b0000000001 || rm !== tm) begin
            miscompares++; $display("FAIL d00_ready: got %b (tick %b) want 0000000001", rm, tm);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] got, tm, rm, sm, ec, erm, esm;
        logic rdo;
        bit rd0;
        rd0 = m_rd;
        for (int w = 0; w < 3; w++) begin
            slot(1'b1, 8'hB5, got, tm, rm, sm, rdo);
            model_next(1'b1, 8'hB5, ec, erm, esm);
            vectors++;
            if (got !== 10'b1010101010) begin miscompares++; $display("FAIL b2b_word%0d: got %b want 1010101010", w, got); end
            vectors++;
            if (rdo !== rd0) begin miscompares++; $display("FAIL b2b_rd%0d: got %b want %b", w, rdo, rd0); end
            vectors++;
            if (rm !== 10'b0000000001) begin miscompares++; $display("FAIL b2b_ready%0d: got %b want 0000000001", w, rm); end
        end
    endtask

    task automatic test_idle_fill;
        logic [9:0] got, tm, rm, sm, ec, erm, esm;
        logic rdo;
        bit prev;
        prev = m_rd;
        for (int w = 0; w < 2; w++) begin
            slot(1'b0, 8'h5A, got, tm, rm, sm, rdo);
            model_next(1'b0, 8'h5A, ec, erm, esm);
            vectors++;
            if (got !== ec) begin miscompares++; $display("FAIL fill_word%0d: got %b want %b", w, got, ec); end
            vectors++;
            if (rdo !== !prev) begin miscompares++; $display("FAIL fill_rd%0d: got %b want %b", w, rdo, !prev); end
            vectors++;
            if (tm !== 10'b0000000001) begin miscompares++; $display("FAIL fill_tick%0d: got %b want 0000000001", w, tm); end
            prev = !prev;
        end
    endtask

    task automatic test_random_data;
        logic [9:0] got, tm, rm, sm, ec, erm, esm;
        logic rdo;
        logic [7:0] dir [10] = '{8'hF1, 8'hF2, 8'hF4, 8'hEB, 8'hED, 8'hEE, 8'hE7, 8'h63, 8'h07, 8'hFF};
        logic [7:0] b;
        bit v;
        for (int w = 0; w < 150; w++) begin
            if (w < 10) begin
                v = 1'b1; b = dir[w];
            end else begin
                v = ($urandom_range(0, 3) != 0); b = 8'($urandom);
            end
            slot(v, b, got, tm, rm, sm, rdo);
            model_next(v, b, ec, erm, esm);
            vectors++;
            if (got !== ec) begin miscompares++; $display("FAIL rand_word%0d: byte %h v %0d got %b want %b", w, b, v, got, ec); end
            vectors++;
            if (rdo !== m_rd) begin miscompares++; $display("FAIL rand_rd%0d: got %b want %b", w, rdo, m_rd); end
            vectors++;
            if (rm !== erm) begin miscompares++; $display("FAIL rand_ready%0d: got %b want %b", w, rm, erm); end
        end
    endtask

    task automatic test_disable;
        logic [9:0] got, tm, rm, sm, ec, erm, esm;
        logic rdo;
        logic [10:0] e;
        u_if.dataValid = 1'b0;
        got = '0; rm = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clkTX); #1;
            got = {got[8:0], SerialOut};
            rm  = {rm[8:0], u_if.dataReady};
            if (i == 4) enable = 1'b0;
        end
        e = ref_enc(8'h00, 1'b1, m_rd);
        vectors++;
        if (got !== e[9:0]) begin miscompares++; $display("FAIL dis_word: got %b want %b", got, e[9:0]); end
        vectors++;
        if (rm !== 10'b0) begin miscompares++; $display("FAIL dis_ready: got %b want 0000000000", rm); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clkTX); #1;
            vectors++;
            if ({SerialOut, tick10, syncDone, rdState, u_if.dataReady} !== 5'b0) begin
                miscompares++;
                $display("FAIL dis_idle%0d: got %b want 00000", i, {SerialOut, tick10, syncDone, rdState, u_if.dataReady});
            end
        end
        m_word = 0; m_rd = 1'b0;
        enable = 1'b1;
        slot(1'b0, 8'h00, got, tm, rm, sm, rdo);
        model_next(1'b0, 8'h00, ec, erm, esm);
        vectors++;
        if (got !== COMMA_P) begin miscompares++; $display("FAIL reen_word: got %b want %b", got, COMMA_P); end
        vectors++;
        if (rdo !== m_rd) begin miscompares++; $display("FAIL reen_rd: got %b want %b", rdo, m_rd); end
    endtask

    task automatic test_reset_midword;
        logic [9:0] got, tm, rm, sm, ec, erm, esm;
        logic rdo;
        logic [7:0] b;
        for (int w = 0; w < NUM_SYNC + 1; w++) begin
            b = 8'($urandom);
            slot(1'b1, b, got, tm, rm, sm, rdo);
            model_next(1'b1, b, ec, erm, esm);
            vectors++;
            if (got !== ec) begin miscompares++; $display("FAIL pre_rst_word%0d: got %b want %b", w, got, ec); end
        end
        u_if.dataValid = 1'b1;
        u_if.dataIn    = 8'h3C;
        repeat (3) begin @(posedge clkTX); #1; end
        #2 resetN = 1'b0;
        #1;
        vectors++;
        if ({SerialOut, u_if.dataReady, tick10, syncDone, rdState} !== 5'b0) begin
            miscompares++;
            $display("FAIL midrst_outs: got %b want 00000", {SerialOut, u_if.dataReady, tick10, syncDone, rdState});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clkTX); #1;
            vectors++;
            if ({SerialOut, tick10, syncDone} !== 3'b0) begin
                miscompares++; $display("FAIL midrst_hold%0d: got %b want 000", i, {SerialOut, tick10, syncDone});
            end
        end
        resetN = 1'b1;
        m_word = 0; m_rd = 1'b0;
        for (int w = 0; w < NUM_SYNC + 3; w++) begin
            b = 8'($urandom);
            slot(w >= NUM_SYNC - 1, b, got, tm, rm, sm, rdo);
            model_next(w >= NUM_SYNC - 1, b, ec, erm, esm);
            vectors++;
            if (got !== ec) begin miscompares++; $display("FAIL restart_word%0d: got %b want %b", w, got, ec); end
            vectors++;
            if (rdo !== m_rd) begin miscompares++; $display("FAIL restart_rd%0d: got %b want %b", w, rdo, m_rd); end
            vectors++;
            if (sm !== esm) begin miscompares++; $display("FAIL restart_sync%0d: got %b want %b", w, sm, esm); end
        end
    endtask

    initial begin
        test_reset();
        test_sync_burst();
        test_first_data();
        test_back_to_back();
        test_idle_fill();
        test_random_data();
        test_disable();
        test_reset_midword();
        enable = 1'b0;
        u_if.dataValid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
